// File: rtl/data_mux_arbiter.sv
// ---------------------------------------------------------------------------
// data_mux_arbiter
//   N-channel registered data selector for the memory data path. Each input
//   channel offers a word with a valid/ready handshake; one winner per cycle
//   is chosen by fixed priority or round-robin, or by an explicit force
//   select. The winning word and its channel index are captured into a
//   one-entry output stage that feeds the memory/CPU write port.
//
// Parameters
//   WIDTH    data width per channel
//   N_CH     number of input channels (2..16)
//   RR_MODE  0 = fixed priority (lowest index wins), 1 = round-robin
//   SW       channel-index width (derived)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel word offered
//   in_ready   per-channel word accepted this cycle
//   force_en   bypass arbitration, only force_sel may be granted
//   force_sel  forced channel index (indices >= N_CH grant nothing)
//   out_data   registered selected word
//   out_ch     channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer takes the word when out_valid & out_ready
//   busy       any input valid or output word pending
// ---------------------------------------------------------------------------
module data_mux_arbiter #(
  parameter int WIDTH   = 64,
  parameter int N_CH    = 4,
  parameter int RR_MODE = 1,
  localparam int SW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  force_en,
  input  logic [SW-1:0]         force_sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  logic [SW-1:0]    rr_ptr;
  logic [N_CH-1:0]  grant;
  logic [SW-1:0]    win_idx;
  logic [WIDTH-1:0] win_data;
  logic             ld;
  logic             xfer;

  // The output stage can take a new word whenever it is empty or its
  // current word is being consumed in this same cycle.
  assign ld       = ~out_valid | out_ready;
  assign in_ready = grant & {N_CH{ld}};
  assign xfer     = |(in_valid & in_ready);
  assign busy     = (|in_valid) | out_valid;

  // One-hot grant. Force mode matches force_sel against real channel
  // indices only, so an out-of-range select grants nothing. Round-robin
  // walks from rr_ptr upward with an explicit wrap so a non-power-of-2
  // channel count never produces an index >= N_CH.
  always_comb begin
    logic          found;
    logic [SW:0]   sum;
    logic [SW-1:0] idx;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    if (force_en) begin
      for (int i = 0; i < N_CH; i++) begin
        if (force_sel == SW'(i)) begin
          grant[i] = in_valid[i];
        end
      end
    end else if (RR_MODE == 0) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!found && in_valid[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        sum = {1'b0, rr_ptr} + (SW+1)'(k);
        if (sum >= (SW+1)'(N_CH)) begin
          sum = sum - (SW+1)'(N_CH);
        end
        idx = sum[SW-1:0];
        if (!found && in_valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  // Encode the one-hot grant into an index and pick the matching word.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        win_idx  = SW'(i);
        win_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer. With no transfer the data
  // and channel fields hold; only out_valid falls once the old word drains.
  // Forced transfers do not disturb the round-robin order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (ld) begin
        if (xfer) begin
          out_data  <= win_data;
          out_ch    <= win_idx;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (xfer && !force_en) begin
        rr_ptr <= (win_idx == SW'(N_CH-1)) ? '0 : win_idx + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mux_arbiter
//   Drives a fixed-priority and a round-robin instance from the same inputs.
//   A small arbitration model predicts each accepted word, which is queued
//   per instance and compared when that instance presents it at its output.
// ---------------------------------------------------------------------------
module tb_data_mux_arbiter;

  localparam int W = 16;
  typedef logic [W+1:0] word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [4*W-1:0] in_data;
  logic [3:0]   in_valid;
  logic         force_en;
  logic [1:0]   force_sel;
  logic         out_ready;

  logic [3:0]   in_ready_a  [2];
  logic [W-1:0] out_data_a  [2];
  logic [1:0]   out_ch_a    [2];
  logic         out_valid_a [2];
  logic         busy_a      [2];

  logic [W-1:0] ch_data [4];
  word_t        q_fp [$];
  word_t        q_rr [$];
  int           ptr_m [2];
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  data_mux_arbiter #(.WIDTH(W), .N_CH(4), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a[0]), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data_a[0]), .out_ch(out_ch_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready), .busy(busy_a[0])
  );

  data_mux_arbiter #(.WIDTH(W), .N_CH(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a[1]), .force_en(force_en), .force_sel(force_sel),
    .out_data(out_data_a[1]), .out_ch(out_ch_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready), .busy(busy_a[1])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference arbitration: returns the winning channel or -1.
  function automatic int pick(input logic [3:0] v, input logic fe, input logic [1:0] fs,
                              input int ptr, input int rr);
    int idx;
    if (fe) return v[fs] ? int'(fs) : -1;
    for (int k = 0; k < 4; k++) begin
      idx = (rr != 0) ? (ptr + k) % 4 : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? q_fp.size() : q_rr.size();
  endfunction

  function automatic word_t q_front(input int d);
    return (d == 0) ? q_fp[0] : q_rr[0];
  endfunction

  task automatic q_pop(input int d);
    if (d == 0) void'(q_fp.pop_front());
    else        void'(q_rr.pop_front());
  endtask

  task automatic q_push(input int d, input word_t w);
    if (d == 0) q_fp.push_back(w);
    else        q_rr.push_back(w);
  endtask

  task automatic setData(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] e);
    ch_data[0] = a; ch_data[1] = b; ch_data[2] = c; ch_data[3] = e;
    in_data = {e, c, b, a};
  endtask

  // One clock cycle: drive inputs just after the edge, check ready/busy,
  // then at mid-cycle compare the presented word and queue the next one.
  task automatic applyStimulus(input logic [3:0] v, input logic r,
                               input logic fe, input logic [1:0] fs);
    int         w [2];
    logic       ld [2];
    logic [3:0] exp_rdy;
    word_t      f;
    in_valid = v; out_ready = r; force_en = fe; force_sel = fs;
    #1;
    for (int d = 0; d < 2; d++) begin
      ld[d]   = (q_size(d) == 0) || r;
      w[d]    = pick(v, fe, fs, ptr_m[d], d);
      exp_rdy = (ld[d] && w[d] >= 0) ? (4'b0001 << w[d]) : 4'b0000;
      checkOutput($sformatf("in_ready[%0d]", d), 64'(in_ready_a[d]), 64'(exp_rdy));
      checkOutput($sformatf("busy[%0d]", d), 64'(busy_a[d]), 64'((|v) || (q_size(d) != 0)));
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("out_valid[%0d]", d), 64'(out_valid_a[d]), 64'(q_size(d) != 0));
      if (q_size(d) != 0) begin
        f = q_front(d);
        checkOutput($sformatf("out_data[%0d]", d), 64'(out_data_a[d]), 64'(f[W-1:0]));
        checkOutput($sformatf("out_ch[%0d]", d), 64'(out_ch_a[d]), 64'(f[W+1:W]));
        if (r) q_pop(d);
      end
      if (ld[d] && w[d] >= 0) begin
        q_push(d, {2'(w[d]), ch_data[w[d]]});
        if (!fe) ptr_m[d] = (w[d] + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 4'b1111; out_ready = 1'b1; force_en = 1'b0; force_sel = 2'd0;
    setData(16'd16, 16'd17, 16'd18, 16'd19);
    ptr_m[0] = 0; ptr_m[1] = 0;
    #2;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst_valid[%0d]", d), 64'(out_valid_a[d]), 64'd0);
      checkOutput($sformatf("rst_data[%0d]", d), 64'(out_data_a[d]), 64'd0);
      checkOutput($sformatf("rst_ch[%0d]", d), 64'(out_ch_a[d]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] fixed priority / round-robin stream");
    repeat (4) applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
    setData(16'd16, 16'd75, 16'd27, 16'd556);
    repeat (5) applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);

    $display("[TB] backpressure");
    applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0);
    repeat (3) applyStimulus(4'b1111, 1'b0, 1'b0, 2'd0);
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);

    $display("[TB] forced select");
    repeat (3) applyStimulus(4'b1111, 1'b1, 1'b1, 2'd2);
    checkOutput("rr_ptr_after_force", 64'(u_rr.rr_ptr), 64'(ptr_m[1]));
    applyStimulus(4'b1011, 1'b1, 1'b1, 2'd2);
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);

    $display("[TB] sparse wrap and mid-stream reset");
    applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0);
    checkOutput("rr_ptr_sparse", 64'(u_rr.rr_ptr), 64'd2);
    repeat (3) applyStimulus(4'b1010, 1'b1, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("midrst_valid[%0d]", d), 64'(out_valid_a[d]), 64'd0);
      checkOutput($sformatf("midrst_data[%0d]", d), 64'(out_data_a[d]), 64'd0);
    end
    q_fp.delete(); q_rr.delete();
    ptr_m[0] = 0; ptr_m[1] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
    repeat (2) applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
